reg_pair_unit: RTL
==================

# reg_pair_unit

16-bit register-pair access engine for the ATmega328p core. It sits on the requesting side of the 32×8 general-purpose file register and drives both of that register's read address ports and its single write port. It executes word operations on even-aligned pairs (r(2n+1):r(2n)): word read, ADIW, SBIW, pointer increment/decrement for X/Y/Z, and MOVW. Each word result is written back as two sequential byte writes.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted this cycle when req_valid=1
- req_op  in  3  0=READ, 1=ADIW, 2=SBIW, 3=INC, 4=DEC, 5=MOVW, 6/7=NOP
- req_dst  in  4  destination pair index n (registers 2n, 2n+1)
- req_src  in  4  source pair index; used by MOVW only, other ops read req_dst
- req_imm  in  6  unsigned immediate for ADIW/SBIW
- fr_raddr_1  out  5  low-byte read address to file register
- fr_raddr_2  out  5  high-byte read address to file register
- fr_rdata_1  in  8  low-byte read data (combinational from file register)
- fr_rdata_2  in  8  high-byte read data
- fr_we  out  1  file register write enable
- fr_waddr  out  5  file register write address
- fr_wdata  out  8  file register write data
- done  out  1  one-cycle pulse, result/flags valid
- result  out  16  word result (READ: value read), held until next done
- flag_c, flag_z, flag_n, flag_v  out  1 each  word flags, held until next done

## Operation
- FSM states: IDLE, READ, WR_LO, WR_HI, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, dst, src, imm; go to READ.
- READ:
  - fr_raddr_1=2·s, fr_raddr_2=2·s+1, where s=src for MOVW and s=dst otherwise.
  - Capture v={fr_rdata_2, fr_rdata_1} and compute R.
  - READ and NOP go to DONE. All other ops go to WR_LO.
- Arithmetic is 17-bit.
  - ADIW: R=v+imm.
  - SBIW: R=v−imm.
  - INC: R=v+1.
  - DEC: R=v−1.
  - MOVW, READ: R=v.
  - NOP: R=v, no write.
- WR_LO: fr_we=1, fr_waddr=2·dst, fr_wdata=R[7:0]; go to WR_HI.
- WR_HI: fr_we=1, fr_waddr=2·dst+1, fr_wdata=R[15:8]; go to DONE.
- DONE: done=1, result=R, flags updated; go to IDLE.
- Flags:
  - Z=(R[15:0]==0); N=R[15].
  - ADIW/INC: C=~R15&v15, V=~v15&R15.
  - SBIW/DEC: C=R15&~v15, V=v15&~R15.
  - READ/MOVW/NOP: C=V=0.
- fr_raddr_* are 0 outside READ. fr_we=0 outside WR_LO/WR_HI.
- req_ready=0 in all states except IDLE; req_valid while busy is ignored, not queued.
- Wrap-around: 0xFFFF+1 → 0x0000 with C=1. 0x0000−1 → 0xFFFF with C=1.
- dst=src in MOVW is legal and rewrites the same values.

## Timing
- Request accepted on edge T:
  - READ in cycle T+1.
  - Low-byte write in T+2, high-byte write in T+3.
  - done in T+4.
  - READ and NOP ops: done in T+2.
- Back-to-back: next request can be accepted in the cycle after done (IDLE).
- Reset values: state IDLE, req_ready=1, fr_we=0, fr_waddr=0, fr_wdata=0, fr_raddr_*=0, done=0, result=0x0000, all flags 0.
- Reset mid-operation:
  - Abort immediately; no further writes.
  - If asserted in WR_HI, the low byte already written stays written; the high byte is not written.
  - done does not fire.

## Configuration
- REG_PAIR_FLAGS_EN defined:
  - Flags are computed as above.
  - This is required for the ALU SREG update path.
- REG_PAIR_FLAGS_EN undefined:
  - flag_c/z/n/v are tied to 0 and no flag logic is synthesized.
  - result, writes and timing are identical.

## Test plan
- Reset, then idle 3 cycles → all outputs at reset values, req_ready=1, fr_we never asserted.
- After file register reset (rN=N), ADIW dst=12 imm=0x3F:
  - v=0x1918.
  - T+2: fr_waddr=24, fr_wdata=0x57.
  - T+3: fr_waddr=25, fr_wdata=0x19.
  - T+4: done, result=0x1957, C=Z=N=V=0.
- Preload r30:r31=0x0000, DEC dst=15 → writes 0xFF to addr 30, then 0xFF to addr 31; result=0xFFFF, C=1, N=1, Z=0.
- Preload r26:r27=0xFFFF, INC dst=13 → result=0x0000, Z=1, C=1. MOVW src=2 dst=14 (r4=4, r5=5) → addr 28←0x04, addr 29←0x05, done at T+4.
- READ dst=1 → fr_raddr_1=2, fr_raddr_2=3 at T+1; done at T+2, result=0x0302; fr_we stays 0. A second req_valid held during busy → req_ready=0, no accept until after done.
- ADIW started, rst asserted during WR_HI:
  - low byte write is observed, high byte write is not.
  - done stays 0.
  - outputs return to reset values next cycle.

Source files
------------

// File: rtl/reg_pair_unit.sv
// reg_pair_unit -- 16-bit register-pair access engine for the ATmega328p core.
//
// Executes word operations on even-aligned register pairs r(2n+1):r(2n) of the
// 32x8 general-purpose file register: word READ, ADIW, SBIW, INC, DEC, MOVW.
// The pair is read in one cycle through both file-register read ports. The
// word result is written back as two byte writes: low byte, then high byte.
//
// Optional feature macro: REG_PAIR_FLAGS_EN
//   defined   : flag_c/z/n/v are computed and held until the next done.
//   undefined : flag outputs are tied to 0 and no flag logic exists.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   req_valid/req_ready   request handshake. A request transfers on a rising
//                         edge where req_valid=1 and req_ready=1. req_ready is
//                         high only in IDLE. A request presented while the
//                         unit is busy is ignored, not queued.
//   req_op                0=READ 1=ADIW 2=SBIW 3=INC 4=DEC 5=MOVW 6/7=NOP
//   req_dst, req_src      destination pair and MOVW source pair index
//   req_imm               unsigned 6-bit immediate for ADIW/SBIW
//   fr_raddr_1/2          low/high byte read addresses (0 outside READ)
//   fr_rdata_1/2          combinational read data from the file register
//   fr_we/waddr/wdata     file register write port
//   done                  one-cycle pulse; result and flags are valid
//   result, flag_*        held until the next done
module reg_pair_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [3:0]  req_dst,
  input  logic [3:0]  req_src,
  input  logic [5:0]  req_imm,
  output logic [4:0]  fr_raddr_1,
  output logic [4:0]  fr_raddr_2,
  input  logic [7:0]  fr_rdata_1,
  input  logic [7:0]  fr_rdata_2,
  output logic        fr_we,
  output logic [4:0]  fr_waddr,
  output logic [7:0]  fr_wdata,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v
);

  localparam logic [2:0] OP_READ = 3'd0;
  localparam logic [2:0] OP_ADIW = 3'd1;
  localparam logic [2:0] OP_SBIW = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_MOVW = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [3:0]  dst_q;
  logic [3:0]  src_q;
  logic [5:0]  imm_q;
  logic [15:0] r_q;

  logic [3:0]  rd_pair;
  logic [15:0] v;
  logic [15:0] r_next;
  logic        has_write;

  assign rd_pair   = (op_q == OP_MOVW) ? src_q : dst_q;
  assign v         = {fr_rdata_2, fr_rdata_1};
  assign has_write = (op_q >= OP_ADIW) && (op_q <= OP_MOVW);

  // Only the low 16 bits of the 17-bit sum are ever observed; carry and
  // overflow are derived from bit 15 of operand and result instead.
  always_comb begin
    r_next = v;
    case (op_q)
      OP_ADIW: r_next = v + {10'd0, imm_q};
      OP_SBIW: r_next = v - {10'd0, imm_q};
      OP_INC:  r_next = v + 16'd1;
      OP_DEC:  r_next = v - 16'd1;
      default: r_next = v;
    endcase
  end

  // Port decode from state. The write enable is also masked by rst so that a
  // reset arriving in WR_HI stops the high-byte write from landing on the
  // same edge that aborts the operation.
  always_comb begin
    fr_raddr_1 = 5'd0;
    fr_raddr_2 = 5'd0;
    fr_we      = 1'b0;
    fr_waddr   = 5'd0;
    fr_wdata   = 8'd0;
    case (state)
      S_READ: begin
        fr_raddr_1 = {rd_pair, 1'b0};
        fr_raddr_2 = {rd_pair, 1'b1};
      end
      S_WR_LO: begin
        fr_we    = ~rst;
        fr_waddr = {dst_q, 1'b0};
        fr_wdata = r_q[7:0];
      end
      S_WR_HI: begin
        fr_we    = ~rst;
        fr_waddr = {dst_q, 1'b1};
        fr_wdata = r_q[15:8];
      end
      default: ;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= 3'd0;
      dst_q  <= 4'd0;
      src_q  <= 4'd0;
      imm_q  <= 6'd0;
      r_q    <= 16'd0;
      result <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            dst_q <= req_dst;
            src_q <= req_src;
            imm_q <= req_imm;
            state <= S_READ;
          end
        end
        S_READ: begin
          r_q <= r_next;
          if (has_write) begin
            state <= S_WR_LO;
          end else begin
            // READ/NOP skip write-back; publish the result entering DONE.
            result <= r_next;
            state  <= S_DONE;
          end
        end
        S_WR_LO: state <= S_WR_HI;
        S_WR_HI: begin
          result <= r_q;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef REG_PAIR_FLAGS_EN
  // Flag vector order: {c, z, n, v}.
  logic [3:0] flags_next;
  logic [3:0] flags_pend;

  always_comb begin
    flags_next    = 4'd0;
    flags_next[2] = (r_next == 16'd0);
    flags_next[1] = r_next[15];
    case (op_q)
      OP_ADIW, OP_INC: begin
        flags_next[3] = ~r_next[15] & v[15];
        flags_next[0] = ~v[15] & r_next[15];
      end
      OP_SBIW, OP_DEC: begin
        flags_next[3] = r_next[15] & ~v[15];
        flags_next[0] = v[15] & ~r_next[15];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_pend <= 4'd0;
      {flag_c, flag_z, flag_n, flag_v} <= 4'd0;
    end else if (state == S_READ) begin
      flags_pend <= flags_next;
      if (!has_write) {flag_c, flag_z, flag_n, flag_v} <= flags_next;
    end else if (state == S_WR_HI) begin
      {flag_c, flag_z, flag_n, flag_v} <= flags_pend;
    end
  end
`else
  assign flag_c = 1'b0;
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule
